// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single SDRAM controller port between the line-capture writer and
// the VGA scan-out reader, sequencing each transaction and aborting on a hung controller.
module sdram_port_arbiter #(
   parameter int MAX_RD_RUN = 8,
   parameter int TIMEOUT    = 255,
   parameter int TO_W       = 8
) (
   input  logic        clk25,
   input  logic        rst_n,
   input  logic        rq_rd_req,
   input  logic [21:0] rq_rd_addr,
   output logic        rq_rd_ack,
   output logic [15:0] rq_rd_data,
   input  logic        rq_wr_req,
   input  logic [21:0] rq_wr_addr,
   input  logic [15:0] rq_wr_data,
   output logic        rq_wr_ack,
   output logic [21:0] rd_addr,
   output logic        rd_enable,
   input  logic [15:0] rd_data,
   input  logic        rd_ready,
   output logic [21:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        wr_enable,
   input  logic        busy,
   output logic        timeout_err,
   output logic [2:0]  state_dbg
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RD_ISSUE = 3'd1;
   localparam logic [2:0] ST_RD_WAIT  = 3'd2;
   localparam logic [2:0] ST_WR_ISSUE = 3'd3;
   localparam logic [2:0] ST_WR_WAIT  = 3'd4;
   localparam logic [2:0] ST_GAP      = 3'd5;

   localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

   localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RD_RUN);
   localparam logic [TO_W-1:0]  TO_ZERO  = {TO_W{1'b0}};
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

   logic [2:0]       state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             rd_en_q, rd_en_d;
   logic             wr_en_q, wr_en_d;
   logic [21:0]      rd_addr_q, rd_addr_d;
   logic [21:0]      wr_addr_q, wr_addr_d;
   logic [15:0]      wr_data_q, wr_data_d;
   logic [15:0]      rd_data_q, rd_data_d;
   logic             rd_ack_q, rd_ack_d;
   logic             wr_ack_q, wr_ack_d;
   logic             to_err_q, to_err_d;

   logic [TO_W-1:0]  to_inc_s;
   logic             to_hit_s;
   logic             rd_grant_s;

   // The counter value after this cycle; reaching TIMEOUT means the transaction is abandoned.
   assign to_inc_s   = to_cnt_q + TO_ONE;
   assign to_hit_s   = (to_inc_s == TO_MAX);
   assign rd_grant_s = rq_rd_req && (!rq_wr_req || (run_q < RUN_MAX));

   // Next-state and output decode for the arbitration and transaction sequencer.
   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      to_cnt_d  = to_cnt_q;
      rd_en_d   = rd_en_q;
      wr_en_d   = wr_en_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_data_d = rd_data_q;
      rd_ack_d  = 1'b0;
      wr_ack_d  = 1'b0;
      to_err_d  = to_err_q;
      case (state_q)
         ST_IDLE: begin
            to_cnt_d = TO_ZERO;
            if (busy) begin
               state_d = ST_IDLE;
            end else if (rd_grant_s) begin
               rd_addr_d = rq_rd_addr;
               rd_en_d   = 1'b1;
               state_d   = ST_RD_ISSUE;
               if (rq_wr_req) begin
                  run_d = run_q + RUN_ONE;
               end else begin
                  run_d = RUN_ZERO;
               end
            end else if (rq_wr_req) begin
               wr_addr_d = rq_wr_addr;
               wr_data_d = rq_wr_data;
               wr_en_d   = 1'b1;
               run_d     = RUN_ZERO;
               state_d   = ST_WR_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_ISSUE: begin
            // Early data completes the read even before busy has been seen.
            if (rd_ready) begin
               rd_en_d   = 1'b0;
               rd_data_d = rd_data;
               rd_ack_d  = 1'b1;
               state_d   = ST_GAP;
            end else if (busy) begin
               rd_en_d  = 1'b0;
               to_cnt_d = TO_ZERO;
               state_d  = ST_RD_WAIT;
            end else if (to_hit_s) begin
               rd_en_d   = 1'b0;
               rd_data_d = 16'h0000;
               rd_ack_d  = 1'b1;
               to_err_d  = 1'b1;
               state_d   = ST_GAP;
            end else begin
               to_cnt_d = to_inc_s;
            end
         end
         ST_RD_WAIT: begin
            if (rd_ready) begin
               rd_data_d = rd_data;
               rd_ack_d  = 1'b1;
               state_d   = ST_GAP;
            end else if (to_hit_s) begin
               rd_data_d = 16'h0000;
               rd_ack_d  = 1'b1;
               to_err_d  = 1'b1;
               state_d   = ST_GAP;
            end else begin
               to_cnt_d = to_inc_s;
            end
         end
         ST_WR_ISSUE: begin
            if (busy) begin
               wr_en_d  = 1'b0;
               wr_ack_d = 1'b1;
               to_cnt_d = TO_ZERO;
               state_d  = ST_WR_WAIT;
            end else if (to_hit_s) begin
               wr_en_d  = 1'b0;
               wr_ack_d = 1'b1;
               to_err_d = 1'b1;
               state_d  = ST_GAP;
            end else begin
               to_cnt_d = to_inc_s;
            end
         end
         ST_WR_WAIT: begin
            // The writer was already acknowledged when busy first rose.
            if (!busy) begin
               state_d = ST_GAP;
            end else if (to_hit_s) begin
               to_err_d = 1'b1;
               state_d  = ST_GAP;
            end else begin
               to_cnt_d = to_inc_s;
            end
         end
         ST_GAP: begin
            to_cnt_d = TO_ZERO;
            state_d  = ST_IDLE;
         end
         default: begin
            rd_en_d  = 1'b0;
            wr_en_d  = 1'b0;
            to_cnt_d = TO_ZERO;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         run_q     <= RUN_ZERO;
         to_cnt_q  <= TO_ZERO;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= 22'h000000;
         wr_addr_q <= 22'h000000;
         wr_data_q <= 16'h0000;
         rd_data_q <= 16'h0000;
         rd_ack_q  <= 1'b0;
         wr_ack_q  <= 1'b0;
         to_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         to_cnt_q  <= to_cnt_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_data_q <= rd_data_d;
         rd_ack_q  <= rd_ack_d;
         wr_ack_q  <= wr_ack_d;
         to_err_q  <= to_err_d;
      end
   end

   assign rq_rd_ack   = rd_ack_q;
   assign rq_rd_data  = rd_data_q;
   assign rq_wr_ack   = wr_ack_q;
   assign rd_addr     = rd_addr_q;
   assign rd_enable   = rd_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign wr_enable   = wr_en_q;
   assign timeout_err = to_err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sdram_port_arbiter;

   localparam int MAX_RD_RUN = 8;
   localparam int TIMEOUT    = 255;
   localparam int TO_W       = 8;

   localparam int P_IDLE = 0, P_RD_ISSUE = 1, P_RD_WAIT = 2, P_WR_ISSUE = 3, P_WR_WAIT = 4, P_GAP = 5;

   logic        clk25;
   logic        rst_n;
   logic        rq_rd_req, rq_wr_req;
   logic [21:0] rq_rd_addr, rq_wr_addr;
   logic [15:0] rq_wr_data;
   logic        rq_rd_ack, rq_wr_ack;
   logic [15:0] rq_rd_data;
   logic [21:0] rd_addr, wr_addr;
   logic        rd_enable, wr_enable;
   logic [15:0] rd_data, wr_data;
   logic        rd_ready, busy;
   logic        timeout_err;
   logic [2:0]  state_dbg;

   sdram_port_arbiter #(.MAX_RD_RUN(MAX_RD_RUN), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk25(clk25), .rst_n(rst_n),
      .rq_rd_req(rq_rd_req), .rq_rd_addr(rq_rd_addr), .rq_rd_ack(rq_rd_ack), .rq_rd_data(rq_rd_data),
      .rq_wr_req(rq_wr_req), .rq_wr_addr(rq_wr_addr), .rq_wr_data(rq_wr_data), .rq_wr_ack(rq_wr_ack),
      .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable), .busy(busy),
      .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   initial clk25 = 1'b0;
   always #5 clk25 = ~clk25;

   int checks = 0;
   int passes = 0;

   // reference model: which transaction phase we are in and what the outputs must be
   int          m_phase = P_IDLE, m_run = 0, m_age = 0;
   logic        m_rd_en = 1'b0, m_wr_en = 1'b0, m_rd_ack = 1'b0, m_wr_ack = 1'b0, m_err = 1'b0;
   logic [21:0] m_rd_addr = 22'h0, m_wr_addr = 22'h0;
   logic [15:0] m_wr_data = 16'h0, m_rd_data = 16'h0;

   task automatic end_read(input logic [15:0] d, input logic aborted);
      m_rd_en   = 1'b0;
      m_rd_data = d;
      m_rd_ack  = 1'b1;
      if (aborted) m_err = 1'b1;
      m_phase   = P_GAP;
   endtask

   task automatic model_step();
      m_rd_ack = 1'b0;
      m_wr_ack = 1'b0;
      if (!rst_n) begin
         m_phase = P_IDLE; m_run = 0; m_age = 0;
         m_rd_en = 1'b0; m_wr_en = 1'b0; m_err = 1'b0;
         m_rd_addr = 22'h0; m_wr_addr = 22'h0; m_wr_data = 16'h0; m_rd_data = 16'h0;
      end else begin
         case (m_phase)
            P_IDLE: begin
               m_age = 0;
               if (!busy && rq_rd_req && !(rq_wr_req && m_run >= MAX_RD_RUN)) begin
                  m_rd_addr = rq_rd_addr;
                  m_rd_en   = 1'b1;
                  m_run     = rq_wr_req ? m_run + 1 : 0;
                  m_phase   = P_RD_ISSUE;
               end else if (!busy && rq_wr_req) begin
                  m_wr_addr = rq_wr_addr;
                  m_wr_data = rq_wr_data;
                  m_wr_en   = 1'b1;
                  m_run     = 0;
                  m_phase   = P_WR_ISSUE;
               end
            end
            P_RD_ISSUE, P_RD_WAIT: begin
               if (rd_ready) end_read(rd_data, 1'b0);
               else if (m_phase == P_RD_ISSUE && busy) begin
                  m_rd_en = 1'b0; m_age = 0; m_phase = P_RD_WAIT;
               end else begin
                  m_age = m_age + 1;
                  if (m_age >= TIMEOUT) end_read(16'h0000, 1'b1);
               end
            end
            P_WR_ISSUE: begin
               if (busy) begin
                  m_wr_en = 1'b0; m_wr_ack = 1'b1; m_age = 0; m_phase = P_WR_WAIT;
               end else begin
                  m_age = m_age + 1;
                  if (m_age >= TIMEOUT) begin
                     m_wr_en = 1'b0; m_wr_ack = 1'b1; m_err = 1'b1; m_phase = P_GAP;
                  end
               end
            end
            P_WR_WAIT: begin
               if (!busy) m_phase = P_GAP;
               else begin
                  m_age = m_age + 1;
                  if (m_age >= TIMEOUT) begin
                     m_err = 1'b1; m_phase = P_GAP;
                  end
               end
            end
            default: m_phase = P_IDLE;
         endcase
      end
   endtask

   task automatic compare();
      logic [83:0] act, exp;
      act = {state_dbg, rd_enable, wr_enable, rd_addr, wr_addr, wr_data,
             rq_rd_ack, rq_wr_ack, rq_rd_data, timeout_err};
      exp = {3'(m_phase), m_rd_en, m_wr_en, m_rd_addr, m_wr_addr, m_wr_data,
             m_rd_ack, m_wr_ack, m_rd_data, m_err};
      checks++;
      if (act === exp) passes++;
      else $display("FAIL model_cmp t=%0t dut=%h model=%h", $time, act, exp);
   endtask

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s actual=%s required=%s", name, act, exp);
   endtask

   task automatic cycle();
      @(posedge clk25);
      model_step();
      #1;
      compare();
      @(negedge clk25);
   endtask

   // cooperative controller: completes reads at once, accepts writes, then releases
   task automatic auto_ctrl();
      rq_rd_addr = 22'($urandom);
      rq_wr_addr = 22'($urandom);
      rq_wr_data = 16'($urandom);
      rd_data    = 16'($urandom_range(1, 65535));
      rd_ready   = (m_phase == P_RD_ISSUE || m_phase == P_RD_WAIT);
      busy       = (m_phase == P_WR_ISSUE);
   endtask

   task automatic drain();
      int budget = 600;
      rq_rd_req = 1'b0;
      rq_wr_req = 1'b0;
      while (m_phase != P_IDLE && budget > 0) begin
         auto_ctrl();
         cycle();
         budget--;
      end
      busy = 1'b0;
      rd_ready = 1'b0;
      check_lit("drain_idle", 32'(state_dbg), 32'd0);
   endtask

   task automatic collect_grants(input int n, output string seq);
      int budget = 2000;
      int got = 0;
      logic [2:0] prev;
      prev = state_dbg;
      seq = "";
      while (got < n && budget > 0) begin
         auto_ctrl();
         cycle();
         if (state_dbg == 3'd1 && prev != 3'd1) begin seq = {seq, "R"}; got++; end
         else if (state_dbg == 3'd3 && prev != 3'd3) begin seq = {seq, "W"}; got++; end
         prev = state_dbg;
         budget--;
      end
   endtask

   initial begin
      string seq;
      int    cnt;
      logic  stuck, quiet;

      rst_n = 1'b0; rq_rd_req = 1'b0; rq_wr_req = 1'b0;
      rq_rd_addr = 22'h0; rq_wr_addr = 22'h0; rq_wr_data = 16'h0;
      rd_data = 16'h0; rd_ready = 1'b0; busy = 1'b0;
      @(negedge clk25);
      cycle();
      cycle();
      check_lit("reset_outs", {rq_rd_data, 6'd0, state_dbg, rd_enable, wr_enable, rq_rd_ack, rq_wr_ack, timeout_err}, 32'd0);
      rst_n = 1'b1;

      // single read
      rq_rd_req = 1'b1; rq_rd_addr = 22'h000281;
      cycle();
      check_lit("rd_grant_en", 32'(rd_enable), 32'd1);
      check_lit("rd_grant_addr", 32'(rd_addr), 32'h000281);
      rq_rd_addr = 22'h3FFFFF;
      cycle();
      check_lit("rd_hold_en", 32'(rd_enable), 32'd1);
      check_lit("rd_addr_stable", 32'(rd_addr), 32'h000281);
      busy = 1'b1;
      cycle();
      check_lit("rd_wait_state", {29'd0, state_dbg}, 32'd2);
      check_lit("rd_wait_en", 32'(rd_enable), 32'd0);
      rd_ready = 1'b1; rd_data = 16'h0ABC;
      cycle();
      check_lit("rd_ack", 32'(rq_rd_ack), 32'd1);
      check_lit("rd_data", 32'(rq_rd_data), 32'h0ABC);
      check_lit("model_rd_data", 32'(m_rd_data), 32'h0ABC);
      check_lit("rd_gap", 32'(state_dbg), 32'd5);
      rq_rd_req = 1'b0; rd_ready = 1'b0; busy = 1'b0;
      cycle();
      check_lit("rd_back_idle", 32'(state_dbg), 32'd0);
      cycle();
      check_lit("rd_no_regrant", {30'd0, rd_enable, rq_rd_ack}, 32'd0);

      // single write
      rq_wr_req = 1'b1; rq_wr_addr = 22'h000105; rq_wr_data = 16'h0FC3;
      cycle();
      check_lit("wr_grant", {wr_enable, 9'd0, wr_addr}, {1'b1, 9'd0, 22'h000105});
      check_lit("wr_data", 32'(wr_data), 32'h0FC3);
      cycle();
      check_lit("wr_hold_en", 32'(wr_enable), 32'd1);
      busy = 1'b1;
      cycle();
      check_lit("wr_ack", {30'd0, wr_enable, rq_wr_ack}, 32'd1);
      check_lit("wr_wait_state", 32'(state_dbg), 32'd4);
      rq_wr_req = 1'b0;
      cycle();
      check_lit("wr_still_wait", 32'(state_dbg), 32'd4);
      busy = 1'b0;
      cycle();
      check_lit("wr_gap", 32'(state_dbg), 32'd5);
      cycle();
      check_lit("wr_idle", 32'(state_dbg), 32'd0);

      // priority and anti-starvation
      rq_rd_req = 1'b1; rq_wr_req = 1'b0;
      collect_grants(20, seq);
      check_str("rd_unlimited", seq, "RRRRRRRRRRRRRRRRRRRR");
      rq_wr_req = 1'b1;
      collect_grants(18, seq);
      check_str("rd_run_limit", seq, "RRRRRRRRWRRRRRRRRW");
      drain();

      // busy gating in IDLE
      busy = 1'b1; rq_rd_req = 1'b1; rq_wr_req = 1'b1; rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_lit("busy_gate", {29'd0, state_dbg, rd_enable, wr_enable}, 32'd0);
      end
      busy = 1'b0;
      cycle();
      check_lit("busy_release_rd", {29'd0, state_dbg, rd_enable, wr_enable}, {27'd0, 3'd1, 2'b10});
      rd_ready = 1'b1; rd_data = 16'h1234;
      cycle();
      check_lit("busy_rd_data", 32'(rq_rd_data), 32'h1234);
      drain();

      // read timeout then a normal write
      rq_rd_req = 1'b1; rq_rd_addr = 22'h012345;
      cycle();
      cnt = 0;
      while (rd_enable && cnt < 400) begin
         cnt++;
         cycle();
      end
      check_lit("to_en_cycles", 32'(cnt), 32'd255);
      check_lit("to_ack", 32'(rq_rd_ack), 32'd1);
      check_lit("to_data", 32'(rq_rd_data), 32'h0000);
      check_lit("to_err", 32'(timeout_err), 32'd1);
      check_lit("model_to_err", 32'(m_err), 32'd1);
      rq_rd_req = 1'b0;
      cycle();
      rq_wr_req = 1'b1; rq_wr_addr = 22'h3ABCDE; rq_wr_data = 16'h5A5A;
      cycle();
      busy = 1'b1;
      cycle();
      check_lit("to_wr_ack", 32'(rq_wr_ack), 32'd1);
      rq_wr_req = 1'b0; busy = 1'b0;
      cycle();
      cycle();
      check_lit("to_err_sticky", {28'd0, state_dbg, timeout_err}, 32'd1);

      // reset in the middle of a read
      rq_rd_req = 1'b1; rq_rd_addr = 22'h0AAAAA;
      cycle();
      busy = 1'b1;
      cycle();
      check_lit("rst_pre_wait", 32'(state_dbg), 32'd2);
      rst_n = 1'b0; rd_ready = 1'b1; rd_data = 16'hBEEF;
      cycle();
      check_lit("rst_outs", {rq_rd_data, 6'd0, state_dbg, rd_enable, wr_enable, rq_rd_ack, rq_wr_ack, timeout_err}, 32'd0);
      check_lit("rst_addr", 32'(rd_addr), 32'd0);
      rst_n = 1'b1; rd_ready = 1'b0; busy = 1'b0; rq_rd_addr = 22'h155555;
      cycle();
      check_lit("rst_regrant", {state_dbg, 7'd0, rd_addr}, {3'd1, 7'd0, 22'h155555});
      rd_ready = 1'b1;
      cycle();
      drain();

      // randomized traffic, with stalled and silent controller windows
      for (int i = 0; i < 4000; i++) begin
         if (m_rd_ack) rq_rd_req = 1'b0;
         else if (!rq_rd_req && $urandom_range(0, 3) == 0) rq_rd_req = 1'b1;
         if (m_wr_ack) rq_wr_req = 1'b0;
         else if (!rq_wr_req && $urandom_range(0, 3) == 0) rq_wr_req = 1'b1;
         rq_rd_addr = 22'($urandom);
         rq_wr_addr = 22'($urandom);
         rq_wr_data = 16'($urandom);
         rd_data    = 16'($urandom);
         stuck = (i >= 1500 && i < 2100);
         quiet = (i >= 2600 && i < 3000);
         busy     = stuck ? 1'b1 : (quiet ? 1'b0 : ($urandom_range(0, 2) == 0));
         rd_ready = (stuck || quiet) ? 1'b0 : ($urandom_range(0, 4) == 0);
         rst_n    = ($urandom_range(0, 799) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
